// File: rtl/eflags_writer.sv
// Two-stage compare pipeline that writes CF/ZF/SF/OF(/PF) into a registered EFLAGS and
// arbitrates direct full-register writes. Define EFLAGS_PARITY_EN to have compares update PF.
module eflags_writer #(
   parameter int unsigned          OPCODE_W   = 8,
   parameter int unsigned          REG_W      = 64,
   parameter logic [OPCODE_W-1:0]  MICRO_CMP  = 8'h20,
   parameter logic [OPCODE_W-1:0]  MICRO_CMPI = 8'h21,
   parameter int unsigned          EFLAGS_CF  = 0,
   parameter int unsigned          EFLAGS_PF  = 2,
   parameter int unsigned          EFLAGS_ZF  = 6,
   parameter int unsigned          EFLAGS_SF  = 7,
   parameter int unsigned          EFLAGS_OF  = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_W-1:0]    lhs,
   input  logic [REG_W-1:0]    rhs,
   input  logic                flush,
   input  logic                wr_en,
   input  logic [REG_W-1:0]    wr_data,
   output logic                wr_ready,
   output logic [REG_W-1:0]    eflags,
   output logic                pending,
   output logic                done
);

`ifdef EFLAGS_PARITY_EN
   localparam bit ParityEn = 1'b1;
`else
   localparam bit ParityEn = 1'b0;
`endif

   localparam logic [REG_W-1:0] EflagsRst = REG_W'(2);

   logic               cmp_accept;
   logic               s1_valid_d, s1_valid_q;
   logic               s2_valid_d, s2_valid_q;
   // S2 only needs the operand signs for OF, so only those are kept from lhs/rhs.
   logic               lhs_sign_d, lhs_sign_q;
   logic               rhs_sign_d, rhs_sign_q;
   logic [REG_W:0]     diff_d, diff_q;
   logic [REG_W-1:0]   eflags_d, eflags_q;
   logic               cf, zf, sf, of, pf;

   assign cmp_accept = in_valid & ~flush & ((opcode == MICRO_CMP) | (opcode == MICRO_CMPI));

   assign pending  = s1_valid_q | s2_valid_q;
   assign wr_ready = ~pending;
   assign done     = s2_valid_q;
   assign eflags   = eflags_q;

   always_comb begin
      s1_valid_d = cmp_accept;
      lhs_sign_d = lhs_sign_q;
      rhs_sign_d = rhs_sign_q;
      diff_d     = diff_q;
      if (cmp_accept) begin
         lhs_sign_d = lhs[REG_W-1];
         rhs_sign_d = rhs[REG_W-1];
         // Extra top bit captures the borrow for CF.
         diff_d     = {1'b0, lhs} - {1'b0, rhs};
      end
   end

   always_comb begin
      cf = diff_q[REG_W];
      zf = (diff_q[REG_W-1:0] == '0);
      sf = diff_q[REG_W-1];
      of = (lhs_sign_q != rhs_sign_q) & (diff_q[REG_W-1] != lhs_sign_q);
      pf = ~^diff_q[7:0];
   end

   always_comb begin
      s2_valid_d = s1_valid_q & ~flush;
      eflags_d   = eflags_q;
      if (wr_en && wr_ready) begin
         eflags_d = wr_data;
      end
      // A flush kills the S2 write too, so eflags holds at the flush edge.
      if (s1_valid_q && !flush) begin
         eflags_d[EFLAGS_CF] = cf;
         eflags_d[EFLAGS_ZF] = zf;
         eflags_d[EFLAGS_SF] = sf;
         eflags_d[EFLAGS_OF] = of;
         if (ParityEn) begin
            eflags_d[EFLAGS_PF] = pf;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         lhs_sign_q <= 1'b0;
         rhs_sign_q <= 1'b0;
         diff_q     <= '0;
         eflags_q   <= EflagsRst;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         lhs_sign_q <= lhs_sign_d;
         rhs_sign_q <= rhs_sign_d;
         diff_q     <= diff_d;
         eflags_q   <= eflags_d;
      end
   end

endmodule

// File: tb/tb_eflags_writer.sv
// Directed bench for eflags_writer: hand-computed EFLAGS values checked with immediate assertions.
module tb_eflags_writer;

   localparam int unsigned OPCODE_W = 8;
   localparam int unsigned REG_W    = 64;
   localparam logic [7:0]  OpCmp    = 8'h20;
   localparam logic [7:0]  OpCmpi   = 8'h21;
   localparam logic [7:0]  OpOther  = 8'h05;

`ifdef EFLAGS_PARITY_EN
   localparam logic [63:0] PfOn = 64'h4;
`else
   localparam logic [63:0] PfOn = 64'h0;
`endif

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic [OPCODE_W-1:0] opcode;
   logic [REG_W-1:0]    lhs;
   logic [REG_W-1:0]    rhs;
   logic                flush;
   logic                wr_en;
   logic [REG_W-1:0]    wr_data;
   logic                wr_ready;
   logic [REG_W-1:0]    eflags;
   logic                pending;
   logic                done;

   int vec_cnt = 0;
   int err_cnt = 0;

   eflags_writer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .opcode   (opcode),
      .lhs      (lhs),
      .rhs      (rhs),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .eflags   (eflags),
      .pending  (pending),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run still active (got timeout, required $finish)");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      assert (got === exp) else begin
         err_cnt++;
         $error("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
      in_valid = 1'b1;
      opcode   = op;
      lhs      = a;
      rhs      = b;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; opcode = '0; lhs = '0; rhs = '0;
      flush = 1'b0; wr_en = 1'b0; wr_data = '0;
      #12;
      chk("rst_eflags",  eflags,   64'h2);
      chk("rst_pending", pending,  64'h0);
      chk("rst_done",    done,     64'h0);
      chk("rst_wrready", wr_ready, 64'h1);
      rst = 1'b0;

      // CMP 5,5
      issue(OpCmp, 64'd5, 64'd5);
      step(); in_valid = 1'b0;
      chk("eq_s1_pending", pending, 64'h1);
      chk("eq_s1_wrready", wr_ready, 64'h0);
      chk("eq_s1_eflags",  eflags,  64'h2);
      chk("eq_s1_done",    done,    64'h0);
      step();
      chk("eq_eflags", eflags, 64'h42 | PfOn);
      chk("eq_done",   done,   64'h1);
      step();
      chk("eq_done_off",   done,    64'h0);
      chk("eq_pending_off", pending, 64'h0);

      // CMPI 3,5: borrow, negative, low byte 0xFE odd parity
      issue(OpCmpi, 64'd3, 64'd5);
      step(); in_valid = 1'b0;
      step();
      chk("lt_eflags", eflags, 64'h83);

      // signed overflow
      issue(OpCmp, 64'h8000_0000_0000_0000, 64'd1);
      step(); in_valid = 1'b0;
      step();
      chk("ovf_eflags", eflags, 64'h802 | PfOn);
      step();

      // non-compare opcode is ignored
      issue(OpOther, 64'd5, 64'd5);
      step(); in_valid = 1'b0;
      chk("ign_pending", pending, 64'h0);
      step();
      chk("ign_eflags", eflags, 64'h802 | PfOn);

      // three back-to-back compares, flush alongside the third
      issue(OpCmp, 64'd5, 64'd5);
      step();
      issue(OpCmp, 64'd3, 64'd5);
      step();
      chk("b2b_first", eflags, 64'h42 | PfOn);
      issue(OpCmp, 64'd3, 64'd5);
      flush = 1'b1;
      step(); in_valid = 1'b0; flush = 1'b0;
      chk("flush_pending", pending, 64'h0);
      chk("flush_eflags",  eflags,  64'h42 | PfOn);
      step(); step();
      chk("flush_hold", eflags, 64'h42 | PfOn);
      chk("flush_done", done,   64'h0);

      // direct write while pending is ignored
      issue(OpCmpi, 64'd3, 64'd5);
      step(); in_valid = 1'b0;
      wr_en = 1'b1; wr_data = 64'h1234;
      chk("wr_busy_ready", wr_ready, 64'h0);
      step(); wr_en = 1'b0;
      chk("wr_busy_eflags", eflags, 64'h83);
      step();
      chk("wr_busy_after", eflags, 64'h83);
      wr_en = 1'b1; wr_data = 64'hFFFF;
      chk("wr_idle_ready", wr_ready, 64'h1);
      step(); wr_en = 1'b0;
      chk("wr_idle_eflags", eflags, 64'hFFFF);

      // compare only touches flag bits
      issue(OpCmp, 64'd3, 64'd5);
      step(); in_valid = 1'b0;
      step();
      chk("preserve", eflags, 64'hF7BF & ~PfOn);
      step();

      // write with flush completes when ready
      wr_en = 1'b1; wr_data = 64'h2; flush = 1'b1;
      step(); wr_en = 1'b0; flush = 1'b0;
      chk("wr_flush", eflags, 64'h2);

      // write and compare in the same cycle: compare overwrites flag bits later
      wr_en = 1'b1; wr_data = 64'hFFFF;
      issue(OpCmp, 64'd5, 64'd5);
      step(); wr_en = 1'b0; in_valid = 1'b0;
      chk("wr_cmp_write", eflags, 64'hFFFF);
      step();
      chk("wr_cmp_flags", eflags, 64'hF77E);
      step();

      // reset one cycle after acceptance
      issue(OpCmpi, 64'd3, 64'd5);
      step(); in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_eflags",  eflags,  64'h2);
      chk("mid_rst_pending", pending, 64'h0);
      rst = 1'b0;
      step();
      chk("post_rst_done1", done,   64'h0);
      chk("post_rst_efl1",  eflags, 64'h2);
      step();
      chk("post_rst_done2", done,   64'h0);
      chk("post_rst_efl2",  eflags, 64'h2);

      // compare accepted on the first edge after release
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      issue(OpCmp, 64'd5, 64'd5);
      step(); in_valid = 1'b0;
      chk("first_edge_pending", pending, 64'h1);
      step();
      chk("first_edge_eflags", eflags, 64'h42 | PfOn);
      chk("first_edge_done",   done,   64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/eflags_writer.md
EFLAGS_WRITER -- requirements
Module: eflags_writer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  compare micro-op presented this cycle.
REQ-004 SHALL have port opcode  input  OPCODE_W  micro-op code; only MICRO_CMP / MICRO_CMPI act.
REQ-005 SHALL have port lhs  input  REG_W  minuend (gs for CMP, gt for CMPI).
REQ-006 SHALL have port rhs  input  REG_W  subtrahend (gt for CMP, sign-extended imm for CMPI).
REQ-007 SHALL have port flush  input  1  kill all in-flight compares.
REQ-008 SHALL have port wr_en  input  1  direct full-register EFLAGS write request.
REQ-009 SHALL have port wr_data  input  REG_W  direct write value.
REQ-010 SHALL have port wr_ready  output  1  direct write accepted this cycle.
REQ-011 SHALL have port eflags  output  REG_W  architectural EFLAGS, registered.
REQ-012 SHALL have port pending  output  1  EFLAGS write in flight; from_eflags consumers stall while high.
REQ-013 SHALL have port done  output  1  one-cycle pulse in the cycle eflags takes a compare result.

Function
REQ-014 SHALL accept a compare when in_valid=1, opcode is MICRO_CMP or MICRO_CMPI, and flush=0; other opcodes are ignored.
REQ-015 SHALL be a 2-stage pipeline: S1 registers lhs, rhs and a REG_W+1-bit difference lhs-rhs; S2 computes flags and writes eflags.
REQ-016 SHALL update eflags exactly 2 rising edges after acceptance; done SHALL be high in the cycle after that edge.
REQ-017 SHALL accept back-to-back compares every cycle with no bubbles and no backpressure.
REQ-018 SHALL set CF = borrow (unsigned lhs<rhs), ZF = (diff==0), SF = diff[REG_W-1].
REQ-019 SHALL set OF = (lhs[MSB]!=rhs[MSB]) & (diff[MSB]!=lhs[MSB]).
REQ-020 SHALL write only the bits at EFLAGS_CF/ZF/SF/OF/PF; all other eflags bits SHALL be preserved.
REQ-021 SHALL drive pending = S1 valid | S2 valid, combinationally from state registers.
REQ-022 SHALL drive wr_ready = ~pending; wr_en with wr_ready=0 SHALL be ignored (no queueing).
REQ-023 SHALL load wr_data into eflags at the edge when wr_en & wr_ready; a compare accepted that same cycle SHALL later overwrite its flag bits.
REQ-024 SHALL clear S1 and S2 valid on flush; eflags SHALL NOT change at that edge; an in_valid coinciding with flush SHALL be dropped.
REQ-025 SHALL give a direct write no effect if flush is also high in the same cycle only when wr_ready=0; with wr_ready=1 the write SHALL complete.

Reset
REQ-026 SHALL on rst clear S1/S2 valid, done=0, pending=0, eflags=0x2 (reserved bit 1 set), asynchronously.
REQ-027 SHALL discard any compare in flight when rst asserts mid-operation; no eflags update follows deassertion.
REQ-028 SHALL accept a compare on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro EFLAGS_PARITY_EN defined, set PF=1 iff diff[7:0] has an even number of ones.
REQ-030 SHALL, without EFLAGS_PARITY_EN, leave the PF bit unchanged by compares (direct writes still set it).

Verification
REQ-031 SHALL cover CMP lhs=5, rhs=5 -> 2 edges later ZF=1 CF=0 SF=0 OF=0, PF=1 (macro on), done pulses once.
REQ-032 SHALL cover CMP lhs=3, rhs=5 -> CF=1 SF=1 ZF=0 OF=0 PF=0 (diff low byte 0xFE); other bits unchanged.
REQ-033 SHALL cover lhs=0x8000_0000_0000_0000, rhs=1 -> OF=1 SF=0 CF=0 ZF=0.
REQ-034 SHALL cover three back-to-back compares with flush in cycle 2 -> only first result lands, pending low after flush edge.
REQ-035 SHALL cover wr_en with pending=1 (ignored, wr_ready=0), then wr_en=1 wr_data=0xFFFF when idle -> eflags=0xFFFF next edge.
REQ-036 SHALL cover rst asserted one cycle after acceptance -> eflags=0x2, pending=0, no done pulse after release.
